keypad_matrix_emu: RTL and testbench

- Synthesizable model of the physical 4x4 matrix keypad, seen from the keypad side of the column/row interface.
- It answers the scanner's active-low column drive with active-low row sense lines for one emulated key.
- A command handshake triggers each press, which can include contact bounce.
- Used on-chip for loopback self-test and in benches that exercise the scanner, debouncer and key-decode path.

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_lfsr.sv | 28 ++
 rtl/keypad_matrix_emu.sv | 135 +++++++++++++
 tb/tb_keypad_matrix_emu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad types: emulator state, key-to-matrix position decode and LFSR taps.
// Reused by the keypad emulator, scanner decode logic and benches.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BOUNCE_PRESS,
    ST_HOLD,
    ST_BOUNCE_REL
  } emu_state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic key_pos_t key_to_pos(input logic [3:0] key);
    key_pos_t pos;
    case (key)
      4'h1: pos = '{row: 2'd0, col: 2'd0};
      4'h2: pos = '{row: 2'd0, col: 2'd1};
      4'h3: pos = '{row: 2'd0, col: 2'd2};
      4'hC: pos = '{row: 2'd0, col: 2'd3};
      4'h4: pos = '{row: 2'd1, col: 2'd0};
      4'h5: pos = '{row: 2'd1, col: 2'd1};
      4'h6: pos = '{row: 2'd1, col: 2'd2};
      4'hD: pos = '{row: 2'd1, col: 2'd3};
      4'h7: pos = '{row: 2'd2, col: 2'd0};
      4'h8: pos = '{row: 2'd2, col: 2'd1};
      4'h9: pos = '{row: 2'd2, col: 2'd2};
      4'hE: pos = '{row: 2'd2, col: 2'd3};
      4'hA: pos = '{row: 2'd3, col: 2'd0};
      4'h0: pos = '{row: 2'd3, col: 2'd1};
      4'hB: pos = '{row: 2'd3, col: 2'd2};
      default: pos = '{row: 2'd3, col: 2'd3};
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/keypad_lfsr.sv
// 16-bit Fibonacci LFSR used as the contact-bounce source of the keypad emulator.
// A zero seed would lock the register, so it is replaced by 16'h0001.
module keypad_lfsr
  import keypad_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED_EFF;
    end else if (en_i) begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/keypad_matrix_emu.sv
// 4x4 matrix keypad emulator: presses one commanded key and answers the column drive.
// Contact bounce phases are present only when KEYPAD_EMU_BOUNCE_EN is defined.
module keypad_matrix_emu
  import keypad_pkg::*;
#(
  parameter int          BOUNCE_CYCLES = 16,
  parameter int          HOLD_W        = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        keypad_cols,
  output logic [3:0]        keypad_rows,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              busy,
  output logic              done
);

  emu_state_t        state_q;
  key_pos_t          pos_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              done_q;
  logic [3:0]        rows_q;
  logic [3:0]        rows_d;
  logic              contact;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BC_W = $clog2(BOUNCE_CYCLES + 1);
  localparam logic [BC_W-1:0] BNC_LOAD = BC_W'(BOUNCE_CYCLES - 1);

  logic [BC_W-1:0] bnc_cnt_q;
  logic [15:0]     lfsr;
  logic [14:0]     unused_lfsr;

  keypad_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (1'b1),
    .lfsr_o (lfsr)
  );
  assign unused_lfsr = lfsr[15:1];
`else
  logic unused_cfg;
  assign unused_cfg = ^{LFSR_SEED, BOUNCE_CYCLES[0]};
`endif

  always_comb begin
    contact = 1'b0;
    case (state_q)
      ST_HOLD: contact = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_BOUNCE_PRESS, ST_BOUNCE_REL: contact = lfsr[0];
`endif
      default: contact = 1'b0;
    endcase
  end

  // Only the latched key's row can be pulled low, and only by its own column.
  always_comb begin
    rows_d = 4'hF;
    if (contact && !keypad_cols[pos_q.col]) begin
      rows_d = ~(4'b0001 << pos_q.row);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pos_q      <= '0;
      hold_cnt_q <= '0;
      done_q     <= 1'b0;
      rows_q     <= 4'hF;
`ifdef KEYPAD_EMU_BOUNCE_EN
      bnc_cnt_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      rows_q <= rows_d;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            pos_q      <= key_to_pos(cmd_key);
            hold_cnt_q <= (cmd_hold == '0) ? '0 : cmd_hold - HOLD_W'(1);
`ifdef KEYPAD_EMU_BOUNCE_EN
            bnc_cnt_q  <= BNC_LOAD;
            state_q    <= ST_BOUNCE_PRESS;
`else
            state_q    <= ST_HOLD;
`endif
          end
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        ST_BOUNCE_PRESS: begin
          if (bnc_cnt_q == '0) begin
            state_q <= ST_HOLD;
          end else begin
            bnc_cnt_q <= bnc_cnt_q - BC_W'(1);
          end
        end
        ST_BOUNCE_REL: begin
          if (bnc_cnt_q == '0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            bnc_cnt_q <= bnc_cnt_q - BC_W'(1);
          end
        end
`endif
        ST_HOLD: begin
          if (hold_cnt_q == '0) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
            bnc_cnt_q <= BNC_LOAD;
            state_q   <= ST_BOUNCE_REL;
`else
            state_q   <= ST_IDLE;
            done_q    <= 1'b1;
`endif
          end else begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign keypad_rows = rows_q;
  assign cmd_ready   = (state_q == ST_IDLE) && !rst;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_keypad_matrix_emu.sv
// Directed bench for keypad_matrix_emu with a per-cycle scoreboard of rows/done/busy.
module tb_keypad_matrix_emu;

  localparam int BC = 8;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BNC = BC;
`else
  localparam int BNC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  keypad_cols = 4'hF;
  logic [3:0]  keypad_rows;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_key = 4'h0;
  logic [15:0] cmd_hold = 16'h0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  keypad_matrix_emu #(.BOUNCE_CYCLES(BC), .HOLD_W(16), .LFSR_SEED(16'hACE1)) dut (
    .clk         (clk),
    .rst         (rst),
    .keypad_cols (keypad_cols),
    .keypad_rows (keypad_rows),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_key     (cmd_key),
    .cmd_hold    (cmd_hold),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic [3:0] rows;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int kr[16];
  int kc[16];
  int rot = 0;
  logic [15:0] m_lfsr;

  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rowval(input logic [3:0] key, input logic [3:0] cols);
    logic [3:0] r;
    r = 4'hF;
    if (!cols[kc[key]]) r[kr[key]] = 1'b0;
    return r;
  endfunction

  task automatic get_cols(input int mode, input logic [3:0] cval, output logic [3:0] cols);
    if (mode == 1) begin
      cols = ~(4'b0001 << rot);
      rot  = (rot + 1) % 4;
    end else begin
      cols = cval;
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rows"}, keypad_rows, e.rows);
      chk({tag, "_done"}, done, e.done);
      chk({tag, "_busy"}, busy, e.busy);
    end
  endtask

  // Entered at a sample point with DUT idle; returns at the done-cycle sample.
  task automatic press(input logic [3:0] key, input int hold, input int mode,
                       input logic [3:0] cval, input bit keep_valid);
    int hl;
    int len;
    logic [3:0] cols_now;
    logic c;
    hl  = (hold == 0) ? 1 : hold;
    len = 2 * BNC + hl;
    chk("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_key   = key;
    cmd_hold  = hold[15:0];
    get_cols(mode, cval, cols_now);
    keypad_cols = cols_now;
    sb.push_back('{rows: 4'hF, done: 1'b0, busy: 1'b1});
    for (int j = 0; j < len; j++) begin
      tick();
      pop_check("seq");
      chk("ready_busy", cmd_ready, 0);
      if (keep_valid) cmd_key = 4'hF;
      else            cmd_valid = 1'b0;
      get_cols(mode, cval, cols_now);
      keypad_cols = cols_now;
      c = (j < BNC || j >= BNC + hl) ? m_lfsr[0] : 1'b1;
      sb.push_back('{rows: c ? rowval(key, cols_now) : 4'hF,
                     done: (j + 1 == len), busy: (j + 1 < len)});
    end
    tick();
    pop_check("done_cyc");
  endtask

  task automatic idle_cycle();
    cmd_valid = 1'b0;
    sb.push_back('{rows: 4'hF, done: 1'b0, busy: 1'b0});
    tick();
    pop_check("idle");
    chk("idle_ready", cmd_ready, 1);
  endtask

  initial begin
    logic [3:0] layout [16];
    layout = '{4'h1, 4'h2, 4'h3, 4'hC, 4'h4, 4'h5, 4'h6, 4'hD,
               4'h7, 4'h8, 4'h9, 4'hE, 4'hA, 4'h0, 4'hB, 4'hF};
    for (int i = 0; i < 16; i++) begin
      kr[layout[i]] = i / 4;
      kc[layout[i]] = i % 4;
    end

    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_key = 4'h5;
    cmd_hold = 16'd4;
    keypad_cols = 4'h0;
    repeat (3) begin
      tick();
      chk("rst_rows", keypad_rows, 4'hF);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("rel_ready", cmd_ready, 1);

    press(4'h5, 4, 0, 4'b1101, 1'b0);
    idle_cycle();
    press(4'h5, 4, 0, 4'b1110, 1'b0);
    idle_cycle();
    press(4'h5, 2, 0, 4'b1111, 1'b0);
    idle_cycle();
    rot = 0;
    press(4'hA, 20, 1, 4'hF, 1'b0);
    idle_cycle();
    press(4'h3, 3, 0, 4'b1011, 1'b1);
    press(4'h5, 2, 0, 4'b1101, 1'b0);
    idle_cycle();
    press(4'h9, 0, 0, 4'b1011, 1'b0);
    idle_cycle();
    press(4'hF, 1, 0, 4'b0000, 1'b0);
    idle_cycle();

    chk("mid_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_key = 4'h5;
    cmd_hold = 16'd10;
    keypad_cols = 4'b1101;
    tick();
    cmd_valid = 1'b0;
    repeat (BNC + 2) tick();
    chk("mid_rows_low", keypad_rows, 4'b1101);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_rows", keypad_rows, 4'hF);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", cmd_ready, 1);
    tick();
    chk("mid_after_done", done, 0);
    chk("mid_after_rows", keypad_rows, 4'hF);

    press(4'h1, 10, 0, 4'b1110, 1'b0);
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
